// File: rtl/muller_hs_tx.sv
// Synchronous 4-phase bundled-data transmitter driving an asynchronous C-element pipeline.
// Optional ack timeout is compiled in when MULLER_HS_TIMEOUT_EN is defined.
module muller_hs_tx #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [7:0]        count_o
);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("muller_hs_tx: SYNC_STAGES must be 2..3 and TIMEOUT 1..255");
  end

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   done_q, done_d;
  logic [7:0]             count_q, count_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_vld_q;
  logic                   ack_s;

  // sync_vld_q marks the synchronizer as refilled after reset, so a stale
  // cleared ack_s cannot let a new request out while the pipeline still acks.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q     <= '0;
      sync_vld_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ack_i};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign in_ready = (state_q == IDLE) && sync_vld_q[SYNC_STAGES-1] && !ack_s;

`ifdef MULLER_HS_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       abort_q, abort_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    count_d = count_q;
`ifdef MULLER_HS_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    abort_d   = abort_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = REQ_HI;
`ifdef MULLER_HS_TIMEOUT_EN
          tmo_cnt_d = 8'd0;
          abort_d   = 1'b0;
`endif
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end else begin
`ifdef MULLER_HS_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_d == TMO_LIMIT) begin
            timeout_d = 1'b1;
            abort_d   = 1'b1;
            req_d     = 1'b0;
            state_d   = REQ_LO;
          end
`endif
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef MULLER_HS_TIMEOUT_EN
          if (!abort_q) count_d = count_q + 8'd1;
`else
          count_d = count_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

`ifdef MULLER_HS_TIMEOUT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= 8'd0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign req_o   = req_q;
  assign data_o  = data_q;
  assign done_o  = done_q;
  assign count_o = count_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_muller_hs_tx.sv
// Directed bench for muller_hs_tx: handshake latency, data hold, counter wrap,
// reset mid-handshake and the ack-timeout behaviour of the configured build.
module tb_muller_hs_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       req;
  logic [3:0] data;
  logic       ack;
  logic       busy;
  logic       done;
  logic       tmo;
  logic [7:0] count;

  logic       echo_en;
  logic       ack_man;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instant responder when echo_en is set, otherwise a manually driven ack.
  assign ack = echo_en ? req : ack_man;

  muller_hs_tx #(
    .DATA_W      (4),
    .SYNC_STAGES (2),
    .TIMEOUT     (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req_o     (req),
    .data_o    (data),
    .ack_i     (ack),
    .busy_o    (busy),
    .done_o    (done),
    .timeout_o (tmo),
    .count_o   (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int dones;
    int cyc;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    echo_en  = 1'b0;
    ack_man  = 1'b0;
    tick();
    tick();
    check("rst_req",     32'(req),      32'd0);
    check("rst_data",    32'(data),     32'd0);
    check("rst_done",    32'(done),     32'd0);
    check("rst_timeout", 32'(tmo),      32'd0);
    check("rst_count",   32'(count),    32'd0);
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_ready",   32'(in_ready), 32'd0);

    rst = 1'b0;
    tick();
    tick();
    check("primed_ready", 32'(in_ready), 32'd1);

    // Single transfer of 4'hA with an instant responder: done 6 cycles after acceptance.
    echo_en  = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hA;
    tick();
    in_valid = 1'b0;
    check("t1_req_rise", 32'(req),      32'd1);
    check("t1_data",     32'(data),     32'hA);
    check("t1_busy",     32'(busy),     32'd1);
    check("t1_ready",    32'(in_ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1_no_done", 32'(done), 32'd0);
      check("t1_hold",    32'(data), 32'hA);
    end
    tick();
    check("t1_done",  32'(done),  32'd1);
    check("t1_count", 32'(count), 32'd1);
    check("t1_idle",  32'(busy),  32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // in_data toggling while busy must not disturb data_o, and in_valid is ignored.
    in_valid = 1'b1;
    in_data  = 4'h5;
    tick();
    check("t2_data", 32'(data), 32'h5);
    for (int k = 1; k <= 5; k++) begin
      in_data = in_data ^ 4'hF;
      tick();
      check("t2_hold",    32'(data), 32'h5);
      check("t2_no_done", 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("t2_done",  32'(done),  32'd1);
    check("t2_count", 32'(count), 32'd2);

    // 256 back-to-back transfers from reset: counter wraps to 0, one transfer per 7 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    dones = 0;
    cyc   = 0;
    while (dones < 256 && cyc < 2500) begin
      in_data = 4'(cyc);
      tick();
      cyc++;
      if (done) dones++;
    end
    in_valid = 1'b0;
    check("b2b_dones",  32'(dones), 32'd256);
    check("b2b_cycles", 32'(cyc),   32'd1792);
    check("b2b_count",  32'(count), 32'd0);
    tick();
    check("b2b_no_extra", 32'(busy), 32'd0);

    // Reset in REQ_HI while the pipeline acknowledges.
    echo_en  = 1'b0;
    ack_man  = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h3;
    tick();
    in_valid = 1'b0;
    check("r_req_hi", 32'(req), 32'd1);
    ack_man = 1'b1;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    check("r_req_drop", 32'(req),   32'd0);
    check("r_count",    32'(count), 32'd0);
    check("r_busy",     32'(busy),  32'd0);
    in_valid = 1'b1;
    in_data  = 4'h9;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("r_ready_blocked", 32'(in_ready), 32'd0);
      check("r_req_blocked",   32'(req),      32'd0);
    end
    ack_man = 1'b0;
    tick();
    check("r_ready_sync1", 32'(in_ready), 32'd0);
    tick();
    check("r_ready_sync2", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("r_accept_req",  32'(req),  32'd1);
    check("r_accept_data", 32'(data), 32'h9);

`ifdef MULLER_HS_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("tmo_wait_req", 32'(req), 32'd1);
      check("tmo_wait_flag", 32'(tmo), 32'd0);
    end
    tick();
    check("tmo_req_fall", 32'(req),  32'd0);
    check("tmo_flag",     32'(tmo),  32'd1);
    check("tmo_busy",     32'(busy), 32'd1);
    tick();
    check("tmo_done",  32'(done),     32'd1);
    check("tmo_count", 32'(count),    32'd0);
    check("tmo_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    check("tmo_sticky", 32'(tmo), 32'd1);
`else
    for (int k = 1; k <= 1000; k++) tick();
    check("hang_req",     32'(req),   32'd1);
    check("hang_timeout", 32'(tmo),   32'd0);
    check("hang_busy",    32'(busy),  32'd1);
    check("hang_data",    32'(data),  32'h9);
    check("hang_count",   32'(count), 32'd0);
`endif

    // Reset beats a simultaneous acceptance attempt.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h7;
    tick();
    check("prio_req",     32'(req),   32'd0);
    check("prio_busy",    32'(busy),  32'd0);
    check("prio_data",    32'(data),  32'd0);
    check("prio_timeout", 32'(tmo),   32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
